// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32IC instruction fetch unit with prefetch queue and redirect flush
//
// Issues word-aligned reads to instruction RAM, buffers the returned words in a
// DEPTH-entry prefetch queue and presents one aligned instruction (16-bit RVC or
// 32-bit, including 32-bit instructions straddling a word boundary) per handshake.
// A redirect flushes the queue and drops every response still in flight.
//
// Ports:
//   clk_i            clock
//   rst_n_i          asynchronous active-low reset
//   iram_rd_en_o     read request valid
//   iram_rd_addr_o   read request address (word aligned)
//   iram_rd_ready_i  read request accepted when en & ready
//   iram_rd_valid_i  read response valid (in request order, latency >= 1)
//   iram_rd_data_i   read response word (little-endian halfwords)
//   redirect_i       flush and restart fetch at redirect_pc_i
//   redirect_pc_i    new PC (bit 0 forced to 0)
//   inst_valid_o     inst_data_o / inst_pc_o hold a complete instruction
//   inst_ready_i     decode consumes the instruction when valid & ready
//   inst_data_o      instruction (RVC zero-extended into [31:16])
//   inst_pc_o        PC of inst_data_o

module inst_fetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            iram_rd_en_o,
    output logic [XLEN-1:0] iram_rd_addr_o,
    input  logic            iram_rd_ready_i,
    input  logic            iram_rd_valid_i,
    input  logic [31:0]     iram_rd_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_data_o,
    output logic [XLEN-1:0] inst_pc_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [XLEN-1:0] HALF_MASK = ~XLEN'(1);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
    localparam logic [CW:0]     CREDITS   = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] pc_q;
    logic            hoff;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     queue [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Head extraction
    logic [31:0] head;
    logic [15:0] next_lo;
    logic [15:0] half;
    logic        is_rvc;
    logic        need_two;

    always_comb begin
        head     = queue[rd_ptr];
        next_lo  = queue[ptr_inc(rd_ptr)][15:0];
        half     = hoff ? head[31:16] : head[15:0];
        is_rvc   = (half[1:0] != 2'b11);
        // A 32-bit instruction starting in the upper half needs the next word too.
        need_two = hoff & ~is_rvc;
    end

    assign inst_valid_o = (count != '0) && (!need_two || (count >= CW'(2)));
    assign inst_pc_o    = pc_q;

    always_comb begin
        inst_data_o = '0;
        if (inst_valid_o) begin
            if (is_rvc)
                inst_data_o = {16'h0, half};
            else if (hoff)
                inst_data_o = {next_lo, head[31:16]};
            else
                inst_data_o = head;
        end
    end

    // Request issue: credits cover both buffered words and words still in flight,
    // so a returning response always finds a free queue slot.
    logic          issue;
    logic          resp;
    logic          push;
    logic          consume;
    logic          pop;
    logic [CW-1:0] discard_load;

    assign iram_rd_en_o   = (state == FETCH) && !redirect_i &&
                            (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    assign iram_rd_addr_o = fetch_addr;

    assign issue        = iram_rd_en_o & iram_rd_ready_i;
    assign resp         = iram_rd_valid_i;
    assign push         = resp && (discard == '0) && !redirect_i;
    assign consume      = inst_valid_o && inst_ready_i && !redirect_i;
    // Only an RVC in the lower half leaves part of the head word unused.
    assign pop          = consume && (hoff || !is_rvc);
    // The response arriving in the redirect cycle is dropped right away.
    assign discard_load = outstanding - CW'(resp);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:  state <= FETCH;
                FETCH: if (redirect_i && discard_load != '0) state <= DRAIN;
                DRAIN: begin
                    if (redirect_i)
                        state <= DRAIN;
                    else if (discard == '0 || (resp && discard == CW'(1)))
                        state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_addr  <= RESET_PC & WORD_MASK;
            pc_q        <= RESET_PC & HALF_MASK;
            hoff        <= RESET_PC[1];
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_i) begin
            fetch_addr  <= redirect_pc_i & WORD_MASK;
            pc_q        <= redirect_pc_i & HALF_MASK;
            hoff        <= redirect_pc_i[1];
            outstanding <= discard_load;
            discard     <= discard_load;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (issue)
                fetch_addr <= fetch_addr + XLEN'(4);
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (resp && discard != '0)
                discard <= discard - CW'(1);
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
            if (consume) begin
                pc_q <= pc_q + (is_rvc ? XLEN'(2) : XLEN'(4));
                if (is_rvc)
                    hoff <= ~hoff;
            end
        end
    end

    // Queue storage needs no reset; occupancy gates everything read from it.
    always_ff @(posedge clk_i) begin
        if (push)
            queue[wr_ptr] <= iram_rd_data_i;
    end

endmodule
